// File: rtl/vedic_mul32_seq.sv
// 32x32 unsigned sequential multiplier built on a single 16x16 Vedic (Urdhva) core.
// The four half-products are issued over consecutive cycles and shift-accumulated into 64 bits.

module vedic_2bits (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic [3:0] o_p
);
  logic w_x0;
  logic w_x1;
  logic w_hh;
  logic w_c;

  assign w_x0   = i_a[1] & i_b[0];
  assign w_x1   = i_a[0] & i_b[1];
  assign w_hh   = i_a[1] & i_b[1];
  assign w_c    = w_x0 & w_x1;
  assign o_p[0] = i_a[0] & i_b[0];
  assign o_p[1] = w_x0 ^ w_x1;
  assign o_p[2] = w_hh ^ w_c;
  assign o_p[3] = w_hh & w_c;
endmodule

module vedic_4bits (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);
  logic [3:0] w_ll;
  logic [3:0] w_hl;
  logic [3:0] w_lh;
  logic [3:0] w_hh;
  logic [4:0] w_mid;

  vedic_2bits u_ll (.i_a(i_a[1:0]), .i_b(i_b[1:0]), .o_p(w_ll));
  vedic_2bits u_hl (.i_a(i_a[3:2]), .i_b(i_b[1:0]), .o_p(w_hl));
  vedic_2bits u_lh (.i_a(i_a[1:0]), .i_b(i_b[3:2]), .o_p(w_lh));
  vedic_2bits u_hh (.i_a(i_a[3:2]), .i_b(i_b[3:2]), .o_p(w_hh));

  assign w_mid = {1'b0, w_hl} + {1'b0, w_lh};
  assign o_p   = {w_hh, w_ll} + {1'b0, w_mid, 2'b00};
endmodule

module vedic_8bits (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_p
);
  logic [7:0] w_ll;
  logic [7:0] w_hl;
  logic [7:0] w_lh;
  logic [7:0] w_hh;
  logic [8:0] w_mid;

  vedic_4bits u_ll (.i_a(i_a[3:0]), .i_b(i_b[3:0]), .o_p(w_ll));
  vedic_4bits u_hl (.i_a(i_a[7:4]), .i_b(i_b[3:0]), .o_p(w_hl));
  vedic_4bits u_lh (.i_a(i_a[3:0]), .i_b(i_b[7:4]), .o_p(w_lh));
  vedic_4bits u_hh (.i_a(i_a[7:4]), .i_b(i_b[7:4]), .o_p(w_hh));

  assign w_mid = {1'b0, w_hl} + {1'b0, w_lh};
  assign o_p   = {w_hh, w_ll} + {3'b000, w_mid, 4'h0};
endmodule

module vedic_16bits (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [31:0] o_p
);
  logic [15:0] w_ll;
  logic [15:0] w_hl;
  logic [15:0] w_lh;
  logic [15:0] w_hh;
  logic [16:0] w_mid;

  vedic_8bits u_ll (.i_a(i_a[7:0]),  .i_b(i_b[7:0]),  .o_p(w_ll));
  vedic_8bits u_hl (.i_a(i_a[15:8]), .i_b(i_b[7:0]),  .o_p(w_hl));
  vedic_8bits u_lh (.i_a(i_a[7:0]),  .i_b(i_b[15:8]), .o_p(w_lh));
  vedic_8bits u_hh (.i_a(i_a[15:8]), .i_b(i_b[15:8]), .o_p(w_hh));

  assign w_mid = {1'b0, w_hl} + {1'b0, w_lh};
  assign o_p   = {w_hh, w_ll} + {7'd0, w_mid, 8'h00};
endmodule

module vedic_mul32_seq #(
  parameter logic PP_REG    = 1'b0,
  parameter logic ZERO_SKIP = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [63:0] Q,
  output logic        BUSY
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_step;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [63:0] r_acc;
  logic [63:0] r_q;
  logic [31:0] r_pp;
  logic [1:0]  r_pp_step;
  logic        r_pp_vld;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_busy;
  logic        w_in_ready_nxt;
  logic        w_out_valid_nxt;
  logic        w_busy_nxt;
  logic [15:0] w_op_a;
  logic [15:0] w_op_b;
  logic [31:0] w_prod;
  logic [63:0] w_addend;
  logic [63:0] w_acc_sum;
  logic        w_zero_skip;

  // Step 1 and 2 both carry a 16-bit weight; step 3 carries 32.
  function automatic logic [63:0] shift_pp(input logic [31:0] p, input logic [1:0] step);
    logic [63:0] s;
    case (step)
      2'd0:    s = {32'd0, p};
      2'd1:    s = {16'd0, p, 16'd0};
      2'd2:    s = {16'd0, p, 16'd0};
      2'd3:    s = {p, 32'd0};
      default: s = 64'd0;
    endcase
    return s;
  endfunction

  assign w_op_a      = r_step[0] ? r_a[31:16] : r_a[15:0];
  assign w_op_b      = r_step[1] ? r_b[31:16] : r_b[15:0];
  assign w_zero_skip = ZERO_SKIP && ((r_a == 32'd0) || (r_b == 32'd0));

  vedic_16bits u_core (.i_a(w_op_a), .i_b(w_op_b), .o_p(w_prod));

  // Selects the term added to the accumulator this cycle.
  always_comb begin
    w_addend = 64'd0;
    if (PP_REG) begin
      if (r_pp_vld) begin
        w_addend = shift_pp(r_pp, r_pp_step);
      end else begin
        w_addend = 64'd0;
      end
    end else begin
      w_addend = shift_pp(w_prod, r_step);
    end
  end

  assign w_acc_sum = r_acc + w_addend;

  // State register and registered handshake/status flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (IN_VALID) begin
          w_next_state = S_CALC;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_CALC: begin
        if ((r_step == 2'd0) && w_zero_skip) begin
          w_next_state = S_DONE;
        end else if (r_step == 2'd3) begin
          w_next_state = PP_REG ? S_DRAIN : S_DONE;
        end else begin
          w_next_state = S_CALC;
        end
      end
      S_DRAIN: w_next_state = S_DONE;
      S_DONE: begin
        if (OUT_READY) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Flag values for the state being entered, so the ports come straight from flops.
  always_comb begin
    w_in_ready_nxt  = 1'b0;
    w_out_valid_nxt = 1'b0;
    w_busy_nxt      = 1'b0;
    case (w_next_state)
      S_IDLE: w_in_ready_nxt = 1'b1;
      S_CALC: w_busy_nxt = 1'b1;
      S_DRAIN: w_busy_nxt = 1'b1;
      S_DONE: begin
        w_out_valid_nxt = 1'b1;
        w_busy_nxt      = 1'b1;
      end
      default: w_in_ready_nxt = 1'b1;
    endcase
  end

  // Operand capture, partial-product pipeline and accumulation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_step    <= 2'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_acc     <= 64'd0;
      r_q       <= 64'd0;
      r_pp      <= 32'd0;
      r_pp_step <= 2'd0;
      r_pp_vld  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (IN_VALID) begin
            r_a      <= A;
            r_b      <= B;
            r_acc    <= 64'd0;
            r_step   <= 2'd0;
            r_pp_vld <= 1'b0;
          end else begin
            r_step <= 2'd0;
          end
        end
        S_CALC: begin
          if ((r_step == 2'd0) && w_zero_skip) begin
            r_q    <= 64'd0;
            r_acc  <= 64'd0;
            r_step <= 2'd0;
          end else if (PP_REG) begin
            r_pp      <= w_prod;
            r_pp_step <= r_step;
            r_pp_vld  <= 1'b1;
            r_acc     <= w_acc_sum;
            r_step    <= r_step + 2'd1;
          end else begin
            r_acc  <= w_acc_sum;
            r_step <= r_step + 2'd1;
            if (r_step == 2'd3) begin
              r_q <= w_acc_sum;
            end else begin
              r_q <= r_q;
            end
          end
        end
        S_DRAIN: begin
          r_acc    <= w_acc_sum;
          r_q      <= w_acc_sum;
          r_pp_vld <= 1'b0;
        end
        S_DONE: r_step <= 2'd0;
        default: r_step <= 2'd0;
      endcase
    end
  end

  assign IN_READY  = r_in_ready;
  assign OUT_VALID = r_out_valid;
  assign BUSY      = r_busy;
  assign Q         = r_q;
endmodule
